// File: rtl/asmd_cnt_unit_pkg.sv
// Shared types for the ASMD counter/flag unit.
// Provides the controller state encoding used by the top-level FSM.
// No ports: package only.
package asmd_pkg;

  // Codes are fixed so that external probes and older logic decode the same states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b11
  } state_e;

endpackage : asmd_pkg

// File: rtl/asmd_cnt_unit_if.sv
// Bundles the control inputs and status outputs of asmd_cnt_unit.
// Ports: start_i/abort_i/auto_rearm_i/init_i from the master;
//        A_o/E_o/F_o/busy_o/done_o returned by the slave (the unit).
interface asmd_cnt_unit_if #(
  parameter int WIDTH = 4
) ();

  logic             start_i;
  logic             abort_i;
  logic             auto_rearm_i;
  logic [WIDTH-1:0] init_i;
  logic [WIDTH-1:0] A_o;
  logic             E_o;
  logic             F_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, abort_i, auto_rearm_i, init_i,
    input  A_o, E_o, F_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, auto_rearm_i, init_i,
    output A_o, E_o, F_o, busy_o, done_o
  );

endinterface : asmd_cnt_unit_if

// File: rtl/asmd_cnt_unit_dp.sv
// Datapath of the ASMD counter unit: counter A, flags E and F.
// Ports: clk_i/rst_b_i, control strobes ld_A/incr_A/ld_E/set_F/clr_F,
//        init_i load value, register outputs A/E/F, status stop_match/e_src.
module asmd_cnt_dp #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] STOP_MASK = 4'b1100,
  parameter int               E_BIT     = 2
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             ld_A_i,
  input  logic             incr_A_i,
  input  logic             ld_E_i,
  input  logic             set_F_i,
  input  logic             clr_F_i,
  input  logic [WIDTH-1:0] init_i,
  output logic [WIDTH-1:0] A_o,
  output logic             E_o,
  output logic             F_o,
  output logic             stop_match_o,
  output logic             e_src_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic             e_q, e_d;
  logic             f_q, f_d;

  // Stop and E-source decode look at the current (pre-increment) A.
  assign stop_match_o = ((a_q & STOP_MASK) == STOP_MASK);
  assign e_src_o      = a_q[E_BIT];

  always_comb begin
    a_d = a_q;
    if (ld_A_i)        a_d = init_i;
    else if (incr_A_i) a_d = a_q + {{(WIDTH-1){1'b0}}, 1'b1};  // wraps silently
  end

  always_comb begin
    e_d = e_q;
    if (ld_E_i) e_d = e_src_o;
  end

  // Set and clear never coincide; clear wins if they ever did.
  always_comb begin
    f_d = f_q;
    if (clr_F_i)      f_d = 1'b0;
    else if (set_F_i) f_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      a_q <= '0;
      e_q <= 1'b0;
      f_q <= 1'b0;
    end else begin
      a_q <= a_d;
      e_q <= e_d;
      f_q <= f_d;
    end
  end

  assign A_o = a_q;
  assign E_o = e_q;
  assign F_o = f_q;

endmodule : asmd_cnt_dp

// File: rtl/asmd_cnt_unit.sv
// Counter/flag unit: controller FSM plus asmd_cnt_dp datapath.
// Ports: clk_i, rst_b_i (async, active-low), bus (slave modport) carrying
//        start/abort/auto_rearm/init in and A/E/F/busy/done out.
module asmd_cnt_unit
  import asmd_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] STOP_MASK = 4'b1100,
  parameter int               E_BIT     = 2
) (
  input  logic           clk_i,
  input  logic           rst_b_i,
  asmd_cnt_unit_if.slave bus
);

  state_e state_q, state_d;

  logic ld_A, incr_A, ld_E, set_F, clr_F;
  logic stop_match, e_src;
  logic busy_d, done_d;

  // State register.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. Abort outranks the stop test in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start_i) state_d = S_RUN;
      S_RUN: begin
        if (bus.abort_i)   state_d = S_IDLE;
        else if (stop_match) state_d = S_DONE;
      end
      S_DONE: state_d = bus.auto_rearm_i ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control strobes (state + inputs) and Moore status (state only).
  always_comb begin
    ld_A   = 1'b0;
    incr_A = 1'b0;
    ld_E   = 1'b0;
    set_F  = 1'b0;
    clr_F  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          ld_A  = 1'b1;
          clr_F = 1'b1;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        if (!bus.abort_i) begin
          incr_A = 1'b1;
          ld_E   = 1'b1;
        end
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
        set_F  = 1'b1;
        ld_A   = bus.auto_rearm_i;
      end
      default: ;
    endcase
  end

  asmd_cnt_dp #(
    .WIDTH    (WIDTH),
    .STOP_MASK(STOP_MASK),
    .E_BIT    (E_BIT)
  ) u_dp (
    .clk_i       (clk_i),
    .rst_b_i     (rst_b_i),
    .ld_A_i      (ld_A),
    .incr_A_i    (incr_A),
    .ld_E_i      (ld_E),
    .set_F_i     (set_F),
    .clr_F_i     (clr_F),
    .init_i      (bus.init_i),
    .A_o         (bus.A_o),
    .E_o         (bus.E_o),
    .F_o         (bus.F_o),
    .stop_match_o(stop_match),
    .e_src_o     (e_src)
  );

  assign bus.busy_o = busy_d;
  assign bus.done_o = done_d;

  // e_src is exposed by the datapath for observability; E is loaded inside it.
  logic unused_e_src;
  assign unused_e_src = e_src;

endmodule : asmd_cnt_unit

// File: tb/tb_asmd_cnt_unit.sv
module tb_asmd_cnt_unit;

  logic clk = 1'b0;
  logic rst_b1 = 1'b0;
  logic rst_b2 = 1'b0;
  always #5 clk = ~clk;

  asmd_cnt_unit_if #(.WIDTH(4)) bus1 ();
  asmd_cnt_unit_if #(.WIDTH(6)) bus2 ();

  asmd_cnt_unit dut1 (
    .clk_i  (clk),
    .rst_b_i(rst_b1),
    .bus    (bus1)
  );

  asmd_cnt_unit #(
    .WIDTH    (6),
    .STOP_MASK(6'b100001),
    .E_BIT    (5)
  ) dut2 (
    .clk_i  (clk),
    .rst_b_i(rst_b2),
    .bus    (bus2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] init;
    int         run_n;
    logic [3:0] a_fin;
    logic       e_fin;
  } vec_t;

  vec_t vecs [7];

  // One start pulse on dut1, run to completion, check timing and final values.
  task automatic run_vec(input vec_t v);
    int cnt;
    @(negedge clk);
    bus1.start_i = 1'b1;
    bus1.init_i  = v.init;
    @(negedge clk);
    bus1.start_i = 1'b0;
    chk("busy_after_start", int'(bus1.busy_o), 1);
    chk("A_loaded", int'(bus1.A_o), int'(v.init));
    cnt = 0;
    while (!bus1.done_o && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("run_cycles", cnt, v.run_n);
    chk("busy_in_done", int'(bus1.busy_o), 1);
    chk("F_low_in_done", int'(bus1.F_o), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(bus1.done_o), 0);
    chk("idle_busy", int'(bus1.busy_o), 0);
    chk("final_A", int'(bus1.A_o), int'(v.a_fin));
    chk("final_E", int'(bus1.E_o), int'(v.e_fin));
    chk("final_F", int'(bus1.F_o), 1);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{4'h0, 13, 4'hD, 1'b1};
    vecs[1] = '{4'hB,  2, 4'hD, 1'b1};
    vecs[2] = '{4'hF,  1, 4'h0, 1'b1};
    vecs[3] = '{4'h5,  8, 4'hD, 1'b1};
    vecs[4] = '{4'hC,  1, 4'hD, 1'b1};
    vecs[5] = '{4'hD,  1, 4'hE, 1'b1};
    vecs[6] = '{4'hE,  1, 4'hF, 1'b1};

    bus1.start_i = 0; bus1.abort_i = 0; bus1.auto_rearm_i = 0; bus1.init_i = '0;
    bus2.start_i = 0; bus2.abort_i = 0; bus2.auto_rearm_i = 0; bus2.init_i = '0;

    repeat (2) @(negedge clk);
    chk("rst_A", int'(bus1.A_o), 0);
    chk("rst_E", int'(bus1.E_o), 0);
    chk("rst_F", int'(bus1.F_o), 0);
    chk("rst_busy", int'(bus1.busy_o), 0);
    chk("rst_done", int'(bus1.done_o), 0);
    rst_b1 = 1'b1;
    rst_b2 = 1'b1;
    @(negedge clk);
    chk("idle_hold_A", int'(bus1.A_o), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort in the 5th RUN cycle; start pulses during RUN must not reload A.
    @(negedge clk);
    bus1.start_i = 1'b1; bus1.init_i = 4'h0;
    @(negedge clk);
    bus1.start_i = 1'b0;                     // RUN cycle 1, A=0
    @(negedge clk); bus1.start_i = 1'b1;     // RUN cycle 2
    @(negedge clk);                          // RUN cycle 3
    @(negedge clk); bus1.start_i = 1'b0;     // RUN cycle 4
    @(negedge clk);                          // RUN cycle 5
    chk("abort_A_before", int'(bus1.A_o), 4);
    bus1.abort_i = 1'b1;
    @(negedge clk);
    bus1.abort_i = 1'b0;
    chk("abort_busy", int'(bus1.busy_o), 0);
    chk("abort_done", int'(bus1.done_o), 0);
    chk("abort_A", int'(bus1.A_o), 4);
    chk("abort_E", int'(bus1.E_o), 0);
    chk("abort_F", int'(bus1.F_o), 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus1.done_o || bus1.A_o != 4'd4) cnt++;
    end
    chk("abort_stays_idle", cnt, 0);

    // Auto re-arm with init B: RUN, RUN, DONE repeating.
    @(negedge clk);
    bus1.start_i = 1'b1; bus1.init_i = 4'hB; bus1.auto_rearm_i = 1'b1;
    @(negedge clk);
    bus1.start_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      chk("rearm_done", int'(bus1.done_o), (i % 3 == 0) ? 1 : 0);
      chk("rearm_A", int'(bus1.A_o), (i % 3 == 1) ? 11 : (i % 3 == 2) ? 12 : 13);
      chk("rearm_F", int'(bus1.F_o), (i >= 4) ? 1 : 0);
      if (i == 7) bus1.auto_rearm_i = 1'b0;
      @(negedge clk);
    end
    chk("rearm_exit_busy", int'(bus1.busy_o), 0);
    chk("rearm_exit_A", int'(bus1.A_o), 13);
    chk("rearm_exit_F", int'(bus1.F_o), 1);

    // Wider instance: stop pattern 100001, E from bit 5.
    @(negedge clk);
    bus2.start_i = 1'b1; bus2.init_i = 6'd0;
    @(negedge clk);
    bus2.start_i = 1'b0;
    cnt = 0;
    while (!bus2.done_o && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("w6_run_cycles", cnt, 34);
    @(negedge clk);
    chk("w6_A", int'(bus2.A_o), 34);
    chk("w6_E", int'(bus2.E_o), 1);
    chk("w6_F", int'(bus2.F_o), 1);
    chk("w6_idle", int'(bus2.busy_o), 0);

    // Reset mid-RUN clears everything without waiting for a clock edge.
    bus2.start_i = 1'b1;
    @(negedge clk);
    bus2.start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("w6_pre_rst_busy", int'(bus2.busy_o), 1);
    rst_b2 = 1'b0;
    #1;
    chk("w6_rst_A", int'(bus2.A_o), 0);
    chk("w6_rst_E", int'(bus2.E_o), 0);
    chk("w6_rst_F", int'(bus2.F_o), 0);
    chk("w6_rst_busy", int'(bus2.busy_o), 0);
    chk("w6_rst_done", int'(bus2.done_o), 0);
    @(negedge clk);
    rst_b2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("w6_post_rst_busy", int'(bus2.busy_o), 0);
    chk("w6_post_rst_A", int'(bus2.A_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_asmd_cnt_unit
